// File: rtl/btn_debounce_toggle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btn_pkg
// Purpose  : Shared state encoding and reset constants for the button
//            debouncer / direction toggler.
// Revision : 1.0 - initial release
// ============================================================================
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic DEC_RESET_VAL = 1'b1;

endpackage : btn_pkg
`default_nettype wire

// File: rtl/btn_debounce_toggle_if.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce_toggle_if
// Purpose  : Button pin in, direction level / press pulse / stable state out.
// Revision : 1.0 - initial release
// ============================================================================
interface btn_debounce_toggle_if;

    logic btn_in;
    logic dec;
    logic press;
    logic btn_stable;

    // Board / stimulus side: drives the pin, observes the conditioned outputs.
    modport master (
        output btn_in,
        input  dec,
        input  press,
        input  btn_stable
    );

    // Debouncer side.
    modport slave (
        input  btn_in,
        output dec,
        output press,
        output btn_stable
    );

endinterface : btn_debounce_toggle_if
`default_nettype wire

// File: rtl/btn_debounce_toggle_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop single-bit synchroniser with a configurable reset level.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter bit RST_VAL = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic d,
    output logic      q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/btn_debounce_toggle.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce_toggle
// Purpose  : Debounces a raw push-button and toggles the counter direction
//            level on every accepted press. Optional macro AUTO_REPEAT_EN
//            adds periodic press pulses while the button is held.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce_toggle
    import btn_pkg::*;
#(
    parameter int unsigned DEB_CNT_W      = 20,
    parameter bit          BTN_ACTIVE_LOW = 1'b1,
    parameter int unsigned REP_CNT_W      = 23
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    btn_debounce_toggle_if.slave  bus
);

    logic                 w_btn_sync;
    logic                 w_b;
    logic                 w_rep_fire;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DEB_CNT_W-1:0] r_cnt;
    logic [DEB_CNT_W-1:0] w_cnt_nxt;
    logic                 r_dec;
    logic                 w_dec_nxt;
    logic                 r_press;
    logic                 w_press_nxt;
    logic                 r_stable;
    logic                 w_stable_nxt;

    // Synchroniser idles at the released pin level so reset looks "not pressed".
    sync_2ff #(
        .RST_VAL (BTN_ACTIVE_LOW)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.btn_in),
        .q     (w_btn_sync)
    );

    assign w_b = w_btn_sync ^ BTN_ACTIVE_LOW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_dec    <= DEC_RESET_VAL;
            r_press  <= 1'b0;
            r_stable <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dec    <= w_dec_nxt;
            r_press  <= w_press_nxt;
            r_stable <= w_stable_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_dec_nxt    = r_dec;
        w_press_nxt  = 1'b0;
        w_stable_nxt = r_stable;

        case (r_state)
            ST_IDLE: begin
                if (w_b) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                // Acceptance needs b still high on the all-ones cycle itself.
                if (!w_b) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (&r_cnt) begin
                    w_state_nxt  = ST_PRESSED;
                    w_cnt_nxt    = '0;
                    w_stable_nxt = 1'b1;
                    w_dec_nxt    = ~r_dec;
                    w_press_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!w_b) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end else if (w_rep_fire) begin
                    w_press_nxt = 1'b1;
                end
            end
            ST_RELEASE_WAIT: begin
                if (w_b) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (&r_cnt) begin
                    w_state_nxt  = ST_IDLE;
                    w_cnt_nxt    = '0;
                    w_stable_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

`ifdef AUTO_REPEAT_EN
    logic [REP_CNT_W-1:0] r_rep_cnt;

    // Held at zero outside PRESSED, so every entry into PRESSED starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt <= '0;
        end else if (r_state != ST_PRESSED) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end

    assign w_rep_fire = (r_state == ST_PRESSED) && (&r_rep_cnt);
`else
    // The repeat interval width has no effect when auto-repeat is absent.
    assign w_rep_fire = (REP_CNT_W == 0) ? 1'b0 : 1'b0;
`endif

    assign bus.dec        = r_dec;
    assign bus.press      = r_press;
    assign bus.btn_stable = r_stable;

endmodule : btn_debounce_toggle
`default_nettype wire

// File: tb/tb_btn_debounce_toggle.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_debounce_toggle
// Purpose  : Directed scoreboard bench for btn_debounce_toggle (4-bit window).
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_debounce_toggle;

    localparam int unsigned DEB_W = 4;
    localparam int unsigned REP_W = 5;

    typedef struct {
        int   at;
        logic dec;
    } press_t;

    logic   clk    = 1'b0;
    logic   rst_n  = 1'b0;
    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    logic   prev_press = 1'b0;
    press_t sb[$];

    btn_debounce_toggle_if bus ();

    btn_debounce_toggle #(
        .DEB_CNT_W      (DEB_W),
        .BTN_ACTIVE_LOW (1'b1),
        .REP_CNT_W      (REP_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_press(input int at, input logic d);
        press_t p;
        p.at  = at;
        p.dec = d;
        sb.push_back(p);
    endtask

    // Every PRESS pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.press === 1'b1) begin
            press_t p;
            chk("press_consecutive", {31'd0, prev_press}, 32'd0);
            chk("press_expected", {31'd0, (sb.size() > 0)}, 32'd1);
            if (sb.size() > 0) begin
                p = sb.pop_front();
                chk("press_cycle", cyc, p.at);
                chk("press_dec", {31'd0, bus.dec}, {31'd0, p.dec});
            end
        end
        prev_press = rst_n ? bus.press : 1'b0;
    end

    initial begin
        int e;
        bus.btn_in = 1'b1;
        rst_n      = 1'b0;
        tick(3);
        chk("rst_dec", bus.dec, 1);
        chk("rst_press", bus.press, 0);
        chk("rst_stable", bus.btn_stable, 0);
        rst_n = 1'b1;
        tick(50);
        chk("idle_dec", bus.dec, 1);
        chk("idle_stable", bus.btn_stable, 0);

        // Clean press, 2 + 16 + 1 clocks of latency.
        bus.btn_in = 1'b0;
        e = cyc;
        expect_press(e + 19, 1'b0);
        tick(18);
        chk("pre_accept_stable", bus.btn_stable, 0);
        chk("pre_accept_dec", bus.dec, 1);
        tick(1);
        chk("accept_stable", bus.btn_stable, 1);
        chk("accept_dec", bus.dec, 0);

        bus.btn_in = 1'b1;
        tick(18);
        chk("pre_release_stable", bus.btn_stable, 1);
        tick(1);
        chk("release_stable", bus.btn_stable, 0);
        chk("release_dec", bus.dec, 0);

        bus.btn_in = 1'b0;
        expect_press(cyc + 19, 1'b1);
        tick(25);
        chk("press2_dec", bus.dec, 1);
        chk("press2_stable", bus.btn_stable, 1);
        bus.btn_in = 1'b1;
        tick(25);
        chk("release2_stable", bus.btn_stable, 0);

        // Bounce: 10 low, 3 high, then held low.
        bus.btn_in = 1'b0;
        tick(10);
        bus.btn_in = 1'b1;
        tick(3);
        bus.btn_in = 1'b0;
        e = cyc;
        expect_press(e + 19, 1'b0);
        tick(10);
        chk("bounce_dec", bus.dec, 1);
        chk("bounce_stable", bus.btn_stable, 0);
        tick(20);
        chk("bounce_hold_dec", bus.dec, 0);
        chk("bounce_hold_stable", bus.btn_stable, 1);

        // Release glitch shorter than the window.
        bus.btn_in = 1'b1;
        tick(8);
        chk("glitch_mid_stable", bus.btn_stable, 1);
        bus.btn_in = 1'b0;
        tick(20);
        chk("glitch_stable", bus.btn_stable, 1);
        chk("glitch_dec", bus.dec, 0);
        bus.btn_in = 1'b1;
        tick(25);
        chk("release3_stable", bus.btn_stable, 0);

        // Bounce exactly on the all-ones cycle must abort, then re-debounce.
        bus.btn_in = 1'b0;
        e = cyc;
        expect_press(e + 36, 1'b1);
        tick(16);
        bus.btn_in = 1'b1;
        tick(1);
        bus.btn_in = 1'b0;
        tick(3);
        chk("lastcycle_stable", bus.btn_stable, 0);
        chk("lastcycle_dec", bus.dec, 0);
        tick(20);
        chk("lastcycle_after_dec", bus.dec, 1);
        chk("lastcycle_after_stable", bus.btn_stable, 1);
        bus.btn_in = 1'b1;
        tick(25);
        chk("release4_stable", bus.btn_stable, 0);

        // Reset at count 12, button held through reset release.
        bus.btn_in = 1'b0;
        tick(15);
        rst_n = 1'b0;
        #1;
        chk("midwait_press", bus.press, 0);
        chk("midwait_stable", bus.btn_stable, 0);
        tick(3);
        rst_n = 1'b1;
        expect_press(cyc + 19, 1'b0);
        tick(19);
        chk("held_dec", bus.dec, 0);
        chk("held_stable", bus.btn_stable, 1);

        // Asynchronous reset after DEC has toggled.
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("async_dec", bus.dec, 1);
        chk("async_stable", bus.btn_stable, 0);
        chk("async_press", bus.press, 0);
        bus.btn_in = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(30);
        chk("post_rst_dec", bus.dec, 1);
        chk("post_rst_stable", bus.btn_stable, 0);

        // Long hold: repeats only with auto-repeat, DEC toggles once.
        bus.btn_in = 1'b0;
        e = cyc;
        expect_press(e + 19, 1'b0);
`ifdef AUTO_REPEAT_EN
        expect_press(e + 51, 1'b0);
        expect_press(e + 83, 1'b0);
        expect_press(e + 115, 1'b0);
`endif
        tick(119);
        chk("hold_dec", bus.dec, 0);
        chk("hold_stable", bus.btn_stable, 1);
        bus.btn_in = 1'b1;
        tick(25);
        chk("hold_release_stable", bus.btn_stable, 0);

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_btn_debounce_toggle
`default_nettype wire
